wshb_arbiter2: RTL and testbench

//  Two-master / one-slave Wishbone arbiter (16-bit data) sharing the single wb16_sdram16 slave.

---
 rtl/wshb_arb_pkg.sv | 25 ++
 rtl/wshb_if.sv | 18 +
 rtl/wshb_arb_mux.sv | 64 ++++++
 rtl/wshb_arbiter2.sv | 141 ++++++++++++++
 tb/tb_wshb_arbiter2.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Width of the per-tenure ack counter used by the hold limit.
    localparam int ARB_CNT_W = 5;

    // Round-robin pick: a lone requester wins; on a tie the master that
    // was not granted last wins. Returns the grant index (0 or 1).
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end else if (req0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle (master drives request, slave drives response).
interface wshb_if #(
    parameter int DATA_BYTES = 2,
    parameter int ADR_W      = 24
) ();
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_W-1:0]        adr;
    logic [DATA_BYTES-1:0]   sel;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic                    ack;
    logic                    err;

    modport master (output cyc, stb, we, adr, sel, dat_ms, input dat_sm, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_ms, output dat_sm, ack, err);
endinterface

// File: rtl/wshb_arb_mux.sv
// Combinational request/response steering for the arbiter.
// The granted master's request goes to the slave; the slave's ack/err go
// back to that master only, and only while it has a strobe on the bus, so a
// late ack after a release (or during a forced stall) is dropped. With no
// grant the slave bus shows cyc=stb=we=0 and the held address/sel/data.
module wshb_arb_mux #(
    parameter int DATA_BYTES = 2,
    parameter int ADR_W      = 24
) (
    input  logic                    gnt_en,
    input  logic                    gnt_idx,
    input  logic                    stb_block,
    input  logic [ADR_W-1:0]        hold_adr,
    input  logic [DATA_BYTES-1:0]   hold_sel,
    input  logic [8*DATA_BYTES-1:0] hold_dat,
    wshb_if.slave                   wb_m0,
    wshb_if.slave                   wb_m1,
    wshb_if.master                  wb_s
);

    logic pick0;
    logic pick1;
    logic fwd_cyc;
    logic fwd_stb;

    assign pick0 = gnt_en & ~gnt_idx;
    assign pick1 = gnt_en &  gnt_idx;

    // Read data is broadcast; only the ack tells a master it is meant for it.
    assign wb_m0.dat_sm = wb_s.dat_sm;
    assign wb_m1.dat_sm = wb_s.dat_sm;

    // Request mux toward the slave and gated response back to the masters.
    always_comb begin
        fwd_cyc     = 1'b0;
        fwd_stb     = 1'b0;
        wb_s.we     = 1'b0;
        wb_s.adr    = hold_adr;
        wb_s.sel    = hold_sel;
        wb_s.dat_ms = hold_dat;
        if (pick0) begin
            fwd_cyc     = wb_m0.cyc;
            fwd_stb     = wb_m0.stb & ~stb_block;
            wb_s.we     = wb_m0.we;
            wb_s.adr    = wb_m0.adr;
            wb_s.sel    = wb_m0.sel;
            wb_s.dat_ms = wb_m0.dat_ms;
        end else if (pick1) begin
            fwd_cyc     = wb_m1.cyc;
            fwd_stb     = wb_m1.stb & ~stb_block;
            wb_s.we     = wb_m1.we;
            wb_s.adr    = wb_m1.adr;
            wb_s.sel    = wb_m1.sel;
            wb_s.dat_ms = wb_m1.dat_ms;
        end
        wb_s.cyc  = fwd_cyc;
        wb_s.stb  = fwd_stb;
        wb_m0.ack = pick0 & fwd_cyc & fwd_stb & wb_s.ack;
        wb_m0.err = pick0 & fwd_cyc & fwd_stb & wb_s.err;
        wb_m1.ack = pick1 & fwd_cyc & fwd_stb & wb_s.ack;
        wb_m1.err = pick1 & fwd_cyc & fwd_stb & wb_s.err;
    end

endmodule

// File: rtl/wshb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter with round-robin cycle grants.
// A grant covers a whole cyc tenure; release and handover are decided in the
// cycle the holder drops cyc, so a waiting master is granted with no gap.
// Optional feature macro: WSHB_ARB_HOLD_LIMIT_EN -- preempts a holder after
// MAX_ACKS acks when the other master is waiting.
// Handshake: Wishbone classic -- a word transfers in a cycle where the
// granted master holds cyc&stb and the slave returns ack (or err).
module wshb_arbiter2
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int MAX_ACKS   = 16,
    parameter int ADR_W      = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    wshb_if.slave      wb_m0,
    wshb_if.slave      wb_m1,
    wshb_if.master     wb_s,
    output arb_state_t state
);

    arb_state_t              state_d;
    logic                    last_gnt;
    logic                    last_d;
    logic                    gnt_en;
    logic                    gnt_idx;
    logic                    cur_cyc;
    logic                    oth_cyc;
    logic                    at_limit;
    logic                    stb_block;
    logic [ADR_W-1:0]        hold_adr;
    logic [DATA_BYTES-1:0]   hold_sel;
    logic [8*DATA_BYTES-1:0] hold_dat;

    assign gnt_en  = (state != ARB_IDLE);
    assign gnt_idx = (state == ARB_GNT1);
    assign cur_cyc = gnt_idx ? wb_m1.cyc : wb_m0.cyc;
    assign oth_cyc = gnt_idx ? wb_m0.cyc : wb_m1.cyc;

`ifdef WSHB_ARB_HOLD_LIMIT_EN
    logic [ARB_CNT_W-1:0] ack_cnt;
    logic [ARB_CNT_W-1:0] ack_cnt_d;

    assign at_limit = (ack_cnt == ARB_CNT_W'(MAX_ACKS));

    // Ack counter: restarts on every grant change, saturates at the limit.
    always_comb begin
        ack_cnt_d = ack_cnt;
        if (state_d != state) begin
            ack_cnt_d = '0;
        end else if (gnt_en && (wb_m0.ack || wb_m1.ack) && !at_limit) begin
            ack_cnt_d = ack_cnt + ARB_CNT_W'(1);
        end
    end

    // Ack counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt_d;
        end
    end
`else
    // Tenure is unbounded; MAX_ACKS has no effect in this build.
    logic unused_max_acks;
    assign unused_max_acks = (MAX_ACKS != 0);
    assign at_limit        = 1'b0;
`endif

    // Stall the holder's strobe once it has used up its tenure and the other
    // master is waiting; the grant moves over at the end of this cycle.
    assign stb_block = gnt_en & at_limit & oth_cyc;

    // Next grant: pick on request from idle; on release or preemption hand
    // over directly to a waiting master, otherwise go idle.
    always_comb begin
        state_d = state;
        last_d  = last_gnt;
        case (state)
            ARB_IDLE: begin
                if (wb_m0.cyc || wb_m1.cyc) begin
                    state_d = rr_pick(wb_m0.cyc, wb_m1.cyc, last_gnt) ? ARB_GNT1 : ARB_GNT0;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!cur_cyc || (at_limit && oth_cyc)) begin
                    last_d = gnt_idx;
                    if (oth_cyc) begin
                        state_d = gnt_idx ? ARB_GNT0 : ARB_GNT1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant state and round-robin history; M0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_d;
            last_gnt <= last_d;
        end
    end

    // Remember the last request driven onto the slave bus so an idle bus
    // keeps its address/data steady instead of following the masters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_adr <= '0;
            hold_sel <= '0;
            hold_dat <= '0;
        end else if (wb_s.cyc) begin
            hold_adr <= wb_s.adr;
            hold_sel <= wb_s.sel;
            hold_dat <= wb_s.dat_ms;
        end
    end

    wshb_arb_mux #(
        .DATA_BYTES (DATA_BYTES),
        .ADR_W      (ADR_W)
    ) u_mux (
        .gnt_en    (gnt_en),
        .gnt_idx   (gnt_idx),
        .stb_block (stb_block),
        .hold_adr  (hold_adr),
        .hold_sel  (hold_sel),
        .hold_dat  (hold_dat),
        .wb_m0     (wb_m0),
        .wb_m1     (wb_m1),
        .wb_s      (wb_s)
    );

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Bench for wshb_arbiter2: two scripted masters, a memory slave with random
// ack latency, and a monitor that checks read data against an expected
// queue filled from a reference memory when each read is issued.
module tb_wshb_arbiter2;
    import wshb_arb_pkg::*;

    localparam int DB        = 2;
    localparam int AW        = 24;
    localparam int DW        = 16;
    localparam int HOLD_ACKS = 16;
    localparam int BURST     = 64;
    localparam int ACK_BOUND = 1000;
`ifdef WSHB_ARB_HOLD_LIMIT_EN
    localparam int EXP_M0_ACKS_BEFORE_M1 = HOLD_ACKS;
`else
    localparam int EXP_M0_ACKS_BEFORE_M1 = BURST;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) m0_if ();
    wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) m1_if ();
    wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) s_if ();
    arb_state_t state;

    wshb_arbiter2 #(.DATA_BYTES(DB), .MAX_ACKS(HOLD_ACKS), .ADR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb_m0   (m0_if),
        .wb_m1   (m1_if),
        .wb_s    (s_if),
        .state   (state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- slave model (memory, 0..2 wait states) ----------------
    logic [DW-1:0] smem [0:8191];
    int unsigned   wait_cnt;
    assign s_if.err = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_if.ack    <= 1'b0;
            s_if.dat_sm <= '0;
            wait_cnt    <= 0;
        end else begin
            s_if.ack <= 1'b0;
            if (s_if.cyc && s_if.stb && !s_if.ack) begin
                if (wait_cnt == 0) begin
                    s_if.ack <= 1'b1;
                    if (s_if.we) smem[s_if.adr[12:0]] <= s_if.dat_ms;
                    else         s_if.dat_sm <= smem[s_if.adr[12:0]];
                    wait_cnt <= $urandom_range(0, 2);
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0] ref_mem [0:8191];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            done_q[$];
    int            exp_order[$];
    int            ack_cnt0 = 0;
    int            ack_cnt1 = 0;
    int            m1_snap  = 0;
    int            tb_last  = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Monitor: every master ack must answer that master's own strobe, never
    // both at once, and read data must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m0_if.ack || m1_if.ack) begin
                total++;
                if ((m0_if.ack && m1_if.ack) ||
                    (m0_if.ack && !(m0_if.cyc && m0_if.stb)) ||
                    (m1_if.ack && !(m1_if.cyc && m1_if.stb))) begin
                    bad++;
                    $display("FAIL ack_legal: ack0=%0b ack1=%0b cyc0=%0b stb0=%0b cyc1=%0b stb1=%0b",
                             m0_if.ack, m1_if.ack, m0_if.cyc, m0_if.stb, m1_if.cyc, m1_if.stb);
                end
            end
            if (m0_if.ack) begin
                ack_cnt0++;
                if (!m0_if.we) begin
                    total++;
                    if (exp_q0.size() == 0) begin
                        bad++;
                        $display("FAIL rd_m0: got %h with no read outstanding", m0_if.dat_sm);
                    end else begin
                        logic [DW-1:0] e0;
                        e0 = exp_q0.pop_front();
                        if (m0_if.dat_sm !== e0) begin
                            bad++;
                            $display("FAIL rd_m0: got %h required %h", m0_if.dat_sm, e0);
                        end
                    end
                end
            end
            if (m1_if.ack) begin
                ack_cnt1++;
                m1_snap = ack_cnt0;
                if (!m1_if.we) begin
                    total++;
                    if (exp_q1.size() == 0) begin
                        bad++;
                        $display("FAIL rd_m1: got %h with no read outstanding", m1_if.dat_sm);
                    end else begin
                        logic [DW-1:0] e1;
                        e1 = exp_q1.pop_front();
                        if (m1_if.dat_sm !== e1) begin
                            bad++;
                            $display("FAIL rd_m1: got %h required %h", m1_if.dat_sm, e1);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic set_req(input int id, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        if (id == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.adr = adr; m0_if.sel = 2'b11; m0_if.dat_ms = dat;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.adr = adr; m1_if.sel = 2'b11; m1_if.dat_ms = dat;
        end
    endtask

    task automatic m_start(input int id, input logic [AW-1:0] adr);
        set_req(id, 1'b1, 1'b0, 1'b0, adr, '0);
    endtask

    task automatic m_stop(input int id);
        if (id == 0) begin m0_if.cyc = 1'b0; m0_if.stb = 1'b0; end
        else         begin m1_if.cyc = 1'b0; m1_if.stb = 1'b0; end
    endtask

    task automatic m_word(input int id, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        logic a;
        int   n;
        if (we) ref_mem[adr[12:0]] = dat;
        else if (id == 0) exp_q0.push_back(ref_mem[adr[12:0]]);
        else exp_q1.push_back(ref_mem[adr[12:0]]);
        set_req(id, 1'b1, 1'b1, we, adr, dat);
        n = 0;
        a = 1'b0;
        while (!a && n < ACK_BOUND) begin
            @(negedge clk);
            a = (id == 0) ? m0_if.ack : m1_if.ack;
            n++;
        end
        if (!a) begin
            total++;
            bad++;
            $display("FAIL ack_wait_m%0d: no ack at adr %h after %0d cycles, ack required", id, adr, n);
        end
        @(posedge clk);
        #1;
        set_req(id, 1'b1, 1'b0, we, adr, dat);
    endtask

    task automatic rr_master(input int id);
        logic [AW-1:0] base;
        for (int k = 0; k < 3; k++) begin
            base = AW'((id == 1 ? 'h1000 : 0) + 'h100 + 8 * k);
            m_start(id, base);
            for (int i = 0; i < 4; i++) begin
                if (i < 2) m_word(id, 1'b1, base + AW'(i), DW'($urandom));
                else       m_word(id, 1'b0, base + AW'(i - 2), '0);
            end
            m_stop(id);
            done_q.push_back(id);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_order(input string name);
        chk({name, "_count"}, 32'(done_q.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < done_q.size(); i++)
            chk(name, 32'(done_q[i]), 32'(exp_order[i]));
        if (done_q.size() > 0) tb_last = done_q[done_q.size() - 1];
        done_q.delete();
        exp_order.delete();
    endtask

    // Bounded watchdog so a stuck handshake still ends the run.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base0;
        int first;
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'(ARB_IDLE));
        chk("rst_s_cyc_stb_we", {29'd0, s_if.cyc, s_if.stb, s_if.we}, 32'd0);
        chk("rst_s_adr", 32'(s_if.adr), 32'd0);
        chk("rst_s_dat", 32'(s_if.dat_ms), 32'd0);
        chk("rst_acks", {30'd0, m0_if.ack, m1_if.ack}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Solo: M0 write then read back; M1 idle must see nothing.
        m_start(0, 24'h10);
        m_word(0, 1'b1, 24'h10, 16'hBEEF);
        m_word(0, 1'b0, 24'h10, '0);
        m_stop(0);
        @(posedge clk);
        #1;
        chk("solo_m1_no_ack", 32'(ack_cnt1), 32'd0);
        chk("idle_adr_held", 32'(s_if.adr), 32'h10);
        chk("idle_cyc_low", {31'd0, s_if.cyc}, 32'd0);

        // Reset in the middle of a granted read.
        set_req(0, 1'b1, 1'b1, 1'b0, 24'h20, '0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_gnt", {31'd0, s_if.cyc}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_s_cyc_stb", {30'd0, s_if.cyc, s_if.stb}, 32'd0);
        chk("midrst_acks", {30'd0, m0_if.ack, m1_if.ack}, 32'd0);
        chk("midrst_state", 32'(state), 32'(ARB_IDLE));
        chk("midrst_adr", 32'(s_if.adr), 32'd0);
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        tb_last = 1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie right after reset: both raise cyc on the same edge.
        first = 1 - tb_last;
        exp_order.push_back(first);
        exp_order.push_back(1 - first);
        fork
            begin
                m_start(0, 24'h40);
                m_word(0, 1'b1, 24'h40, DW'($urandom));
                m_stop(0);
                done_q.push_back(0);
            end
            begin
                m_start(1, 24'h1040);
                m_word(1, 1'b1, 24'h1040, DW'($urandom));
                m_stop(1);
                done_q.push_back(1);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("tie_first_owner", {30'd0, s_if.cyc, s_if.adr[12]}, {30'd0, 1'b1, first[0]});
                for (int n = 0; n < ACK_BOUND && m0_if.cyc; n++) @(negedge clk);
                @(negedge clk);
                chk("tie_second_no_gap", {30'd0, s_if.cyc, s_if.adr[12]}, 32'd3);
            end
        join
        check_order("tie_order");
        @(posedge clk);
        #1;

        // Handover: M0 drops cyc in the same cycle M1 raises it.
        m_start(0, 24'h30);
        m_word(0, 1'b1, 24'h30, DW'($urandom));
        m_stop(0);
        fork
            m_word(1, 1'b1, 24'h1030, DW'($urandom));
            begin
                @(negedge clk);
                @(negedge clk);
                chk("handover_no_gap", {30'd0, s_if.cyc, s_if.adr[12]}, 32'd3);
            end
        join
        m_stop(1);
        tb_last = 1;
        @(posedge clk);
        #1;

        // Round-robin: both keep requesting 4-word cycles.
        first = 1 - tb_last;
        for (int k = 0; k < 6; k++) exp_order.push_back((first + k) % 2);
        fork
            rr_master(0);
            rr_master(1);
        join
        check_order("rr_order");

        // Long M0 burst with one M1 read arriving early in the tenure.
        base0 = ack_cnt0;
        m_start(0, 24'h200);
        fork
            begin
                for (int i = 0; i < BURST; i++) m_word(0, 1'b1, AW'('h200 + i), DW'($urandom));
                m_stop(0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_word(1, 1'b0, 24'h1100, '0);
                m_stop(1);
            end
        join
        chk("hold_m0_acks_before_m1", 32'(m1_snap - base0), 32'(EXP_M0_ACKS_BEFORE_M1));
        @(posedge clk);
        #1;

        // Read back part of the burst to confirm no word was lost.
        m_start(0, 24'h200);
        for (int i = 0; i < 8; i++) m_word(0, 1'b0, AW'('h200 + $urandom_range(0, BURST - 1)), '0);
        m_stop(0);

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
        chk("final_state", 32'(state), 32'(ARB_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
